mm_step_sequencer: RTL

MM_STEP_SEQUENCER -- requirements
Module: mm_step_sequencer

---
 rtl/mm_pkg.sv | 14 +
 rtl/edge_rise_det.sv | 22 ++
 rtl/mm_step_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared constants and FSM encoding for the matrix-multiply step sequencer.
package mm_pkg;

    localparam int unsigned DefaultN    = 4;
    localparam int unsigned DefaultIdxW = 2;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitTick = 2'd1,
        StIssue    = 2'd2,
        StDone     = 2'd3
    } seq_state_t;

endpackage

// File: rtl/edge_rise_det.sv
// One-bit registered rising-edge detector; the input is treated as data, never as a clock.
module edge_rise_det (
    input  logic clock_in,
    input  logic reset_n,
    input  logic level,
    output logic rise
);

    logic level_prev;

    // Keep last cycle's level so a 0->1 transition shows up as a single-cycle rise.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    assign rise = level & ~level_prev;

endmodule

// File: rtl/mm_step_sequencer.sv
// Walks (row, col, k) over an NxN matrix multiply, issuing one MAC strobe per advance event.
module mm_step_sequencer
    import mm_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned IDX_W = DefaultIdxW
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             slow_tick_in,
    input  logic             start,
    input  logic             single_step,
    input  logic             step_req,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic [IDX_W-1:0] k_idx,
    output logic             mac_en,
    output logic             acc_clr,
    output logic             result_we
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] OneIdx  = IDX_W'(1);

    seq_state_t state_q;
    logic       tick_rise;
    logic       step_rise;
    logic       advance;
    logic       last_step;

    edge_rise_det u_tick_det (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .level    (slow_tick_in),
        .rise     (tick_rise)
    );

    edge_rise_det u_step_det (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .level    (step_req),
        .rise     (step_rise)
    );

    // Mode is looked at every cycle, so switching mid-run takes effect on the next edge.
    assign advance   = single_step ? step_rise : tick_rise;
    assign last_step = (row_idx == LastIdx) && (col_idx == LastIdx) && (k_idx == LastIdx);

    // Sequencer FSM and index counters; strobes are registered alongside the state they belong to.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            row_idx   <= '0;
            col_idx   <= '0;
            k_idx     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mac_en    <= 1'b0;
            acc_clr   <= 1'b0;
            result_we <= 1'b0;
        end else begin
            mac_en    <= 1'b0;
            acc_clr   <= 1'b0;
            result_we <= 1'b0;
            done      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // advance is deliberately not looked at here
                    if (start) begin
                        state_q <= StWaitTick;
                        row_idx <= '0;
                        col_idx <= '0;
                        k_idx   <= '0;
                        busy    <= 1'b1;
                    end
                end
                StWaitTick: begin
                    if (advance) begin
                        state_q   <= StIssue;
                        mac_en    <= 1'b1;
                        acc_clr   <= (k_idx == '0);
                        result_we <= (k_idx == LastIdx);
                    end
                end
                StIssue: begin
                    if (last_step) begin
                        // Park indices at zero so they never run past N-1.
                        state_q <= StDone;
                        done    <= 1'b1;
                        row_idx <= '0;
                        col_idx <= '0;
                        k_idx   <= '0;
                    end else begin
                        state_q <= StWaitTick;
                        if (k_idx == LastIdx) begin
                            k_idx <= '0;
                            if (col_idx == LastIdx) begin
                                col_idx <= '0;
                                row_idx <= row_idx + OneIdx;
                            end else begin
                                col_idx <= col_idx + OneIdx;
                            end
                        end else begin
                            k_idx <= k_idx + OneIdx;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
